// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the stopwatch/timer datapath.
// mmss_t packs {min10, min1, sec10, sec1}. The packed layout matches the
// 16-bit display word.
// mmss_inc saturates at 59:59. mmss_dec saturates at 00:00.
package stopwatch_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t min10;
    bcd_digit_t min1;
    bcd_digit_t sec10;
    bcd_digit_t sec1;
  } mmss_t;

  localparam mmss_t MMSS_ZERO = 16'h0000;
  localparam mmss_t MMSS_MAX  = 16'h5959;

  function automatic mmss_t mmss_inc(input mmss_t v);
    mmss_t r;
    r = v;
    if (v != MMSS_MAX) begin
      if (v.sec1 != 4'd9) begin
        r.sec1 = v.sec1 + 4'd1;
      end else begin
        r.sec1 = 4'd0;
        if (v.sec10 != 4'd5) begin
          r.sec10 = v.sec10 + 4'd1;
        end else begin
          r.sec10 = 4'd0;
          if (v.min1 != 4'd9) begin
            r.min1 = v.min1 + 4'd1;
          end else begin
            // min10 cannot pass 5 here because 59:59 is excluded above.
            r.min1  = 4'd0;
            r.min10 = v.min10 + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic mmss_t mmss_dec(input mmss_t v);
    mmss_t r;
    r = v;
    if (v != MMSS_ZERO) begin
      if (v.sec1 != 4'd0) begin
        r.sec1 = v.sec1 - 4'd1;
      end else begin
        r.sec1 = 4'd9;
        if (v.sec10 != 4'd0) begin
          r.sec10 = v.sec10 - 4'd1;
        end else begin
          r.sec10 = 4'd5;
          if (v.min1 != 4'd0) begin
            r.min1 = v.min1 - 4'd1;
          end else begin
            r.min1  = 4'd9;
            r.min10 = v.min10 - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_timer_core_tick_gen.sv
// One-second prescaler for the stopwatch/timer core.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : prescaler counts only while high; otherwise it is held at 0
//   tick : combinational, high on the last cycle of each TICK_DIV period while run
// Holding the count at 0 whenever run is low makes every run start with a
// full second. The first tick lands TICK_DIV cycles after run rises.
module tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == LAST);
  assign tick = run && last;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_timer_core.sv
// Time-keeping datapath of the stopwatch/timer.
// It holds a BCD mm:ss value.
//   - Stopwatch mode counts the value up.
//   - Input mode sets it by button pulses.
//   - Timer mode counts it down, then raises the sticky time-up flag.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   clear             : zero time, prescaler and flag
//   enable            : count up once per second
//   enable_increment  : inc_pulse adds one second
//   enable_decrement  : count down once per second
//   inc_pulse         : single-cycle button pulse
//   time_bcd          : {min10, min1, sec10, sec1}, registered
//   flag              : sticky time-up, registered
//   tick              : one-cycle pulse per applied second change, registered
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        enable_increment,
  input  logic        enable_decrement,
  input  logic        inc_pulse,
  output logic [15:0] time_bcd,
  output logic        flag,
  output logic        tick
);

  mmss_t time_q, time_d;
  logic  flag_q, flag_d;
  logic  tick_q, tick_d;
  logic  run;
  logic  sec_tick;
  mmss_t time_dec;

  // Clear takes priority over the counting modes. Clear must also zero the prescaler.
  assign run = (enable_decrement || enable) && !clear;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (sec_tick)
  );

  assign time_dec = mmss_dec(time_q);

  always_comb begin
    time_d = time_q;
    flag_d = flag_q;
    tick_d = 1'b0;
    if (clear) begin
      time_d = MMSS_ZERO;
      flag_d = 1'b0;
    end else if (enable_decrement) begin
      // Once flag is set, countdown is frozen. The prescaler keeps running with no effect.
      if (!flag_q) begin
        if (time_q == MMSS_ZERO) begin
          flag_d = 1'b1;
        end else if (sec_tick) begin
          time_d = time_dec;
          tick_d = 1'b1;
          if (time_dec == MMSS_ZERO) begin
            flag_d = 1'b1;
          end
        end
      end
    end else if (enable) begin
      if (sec_tick && time_q != MMSS_MAX) begin
        time_d = mmss_inc(time_q);
        tick_d = 1'b1;
      end
    end else if (enable_increment && inc_pulse) begin
      time_d = mmss_inc(time_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q <= MMSS_ZERO;
      flag_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      time_q <= time_d;
      flag_q <= flag_d;
      tick_q <= tick_d;
    end
  end

  assign time_bcd = time_q;
  assign flag     = flag_q;
  assign tick     = tick_q;

endmodule

// File: doc/stopwatch_timer_core.md
Name: stopwatch_timer_core

Overview:
- Time-keeping datapath directly downstream of the mode/sequence FSM.
- Consumes the FSM's clear, enable, enable_increment and enable_decrement strobes.
- Maintains a BCD mm:ss value that counts up in stopwatch mode, is set by button pulses in input mode, and counts down in timer mode.
- Produces the sticky `flag` (time up) the FSM waits on, plus the BCD value for the display mux.

Parameters:
- TICK_DIV, 100_000, clk cycles per one-second tick (≥2); the bench overrides it to 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  zero the time, the prescaler and `flag`
- enable  in  1  stopwatch: count up once per second
- enable_increment  in  1  input mode: `inc_pulse` adds one second
- enable_decrement  in  1  timer: count down once per second
- inc_pulse  in  1  single-cycle pulse from the edge-detected pb1 path
- time_bcd  out  16  {min10, min1, sec10, sec1}, BCD, registered
- flag  out  1  sticky time-up indication, registered
- tick  out  1  one-cycle pulse on each applied second boundary, registered

Behaviour:
- Reset (rst=1 at a clk edge): time_bcd=16'h0000, flag=0, tick=0, prescaler=0. A reset mid-count aborts the count immediately.
- Command priority per cycle: rst > clear > enable_decrement > enable > enable_increment. The lower-priority commands are ignored that cycle.
- clear: time_bcd←0, flag←0, prescaler←0, tick←0.
- Active means enable_decrement=1 or enable=1.
- Prescaler:
  - Counts 0..TICK_DIV-1 while active and wraps to 0.
  - Is forced to 0 whenever not active, so every run begins with a full second. Fractional seconds are discarded on pause; this is decided behaviour.
  - The internal tick fires on the cycle the prescaler equals TICK_DIV-1 while active.
  - The first tick therefore occurs TICK_DIV cycles after active rises.
- tick output: registered copy of the internal tick. It pulses only when the time value actually changes; no pulse occurs at saturation or while already at zero.
- Count up (enable, tick):
  - sec1 increments; 9 → 0 carries into sec10.
  - sec10 5 → 0 carries into min1.
  - min1 9 → 0 carries into min10.
  - min10 saturates: at 59:59 the value holds at 59:59 (no wrap).
- Set (enable_increment & inc_pulse): add one second using the same carry rules. At 59:59 the value holds. Pulses with enable_increment=0 are ignored.
- Count down (enable_decrement, tick):
  - Subtract one second; borrows mirror the carries (sec1 0 → 9, sec10 0 → 5, min1 0 → 9).
  - When the result is 00:00, flag←1 in the same update, so flag and time_bcd=0 are visible together.
- Zero start: enable_decrement=1 with time_bcd already 0 → flag←1 on the next edge, with no tick and no underflow.
- flag:
  - Once set, it holds through any commands until clear or rst.
  - After flag is set, counting down stops: the value stays 0 and the prescaler keeps running without effect.
- All outputs are registered. Command-to-output latency is one clk edge.
- Illegal (non-BCD) digits are unreachable.

Decomposition:
- Shared package `stopwatch_pkg`:
  - typedef `bcd_digit_t` (logic [3:0]);
  - struct `mmss_t` {min10, min1, sec10, sec1};
  - constants `MMSS_ZERO` = 16'h0000 and `MMSS_MAX` = 16'h5959.
- One sub-module `tick_gen` (parameter TICK_DIV; ports clk, rst, run, tick) is natural.
- BCD increment/decrement are combinational functions in the package.

Test Plan:
- Reset: assert rst 2 cycles → time_bcd=0000, flag=0, tick=0. Then pulse inc_pulse with enable_increment=0 → time_bcd stays 0000.
- Stopwatch count (TICK_DIV=4):
  - hold enable from cycle 0 → first tick at cycle 4, time_bcd=0001;
  - after 61 ticks (244 cycles) → 0101;
  - drop enable for 3 cycles, then reassert → next tick 4 cycles after reassertion.
- Set and saturate:
  - enable_increment with 59 inc_pulses → 0059, next pulse → 0100;
  - preload 5959 via clear plus 3599 pulses, then enable for 8 cycles → stays 5959 with no tick.
- Countdown:
  - set 0003, then enable_decrement for 12 cycles → ticks at cycles 4, 8, 12; values 0002, 0001, 0000;
  - flag=1 in the same cycle the value reaches 0000, and it holds for 20 further cycles;
  - clear → flag=0, time_bcd=0000.
- Zero-start and priority:
  - enable_decrement with time 0 → flag=1 one edge later;
  - clear and enable asserted together → clear wins (0000, flag 0);
  - enable and enable_decrement together from 0010 → decrements to 0009.
- Reset mid-operation: countdown at 0005, assert rst for 1 cycle mid-prescale → 0000, flag=0, no tick. The next countdown's first tick comes exactly TICK_DIV cycles after the restart.
